// File: rtl/axi_xbar_fifo_pkg.sv
// Shared definitions for the crossbar same-clock FIFO controller:
// gray-code conversion, level-width helper and status-register bit map.
package axi_xbar_fifo_pkg;

  // Bit positions of the FIFO flags inside the crossbar status register.
  localparam int STAT_FULL_IDX   = 0;
  localparam int STAT_EMPTY_IDX  = 1;
  localparam int STAT_AFULL_IDX  = 2;
  localparam int STAT_AEMPTY_IDX = 3;
  localparam int STAT_OVF_IDX    = 4;
  localparam int STAT_UDF_IDX    = 5;
  localparam int STAT_W          = 6;

  // Level and threshold values must hold 0..DEPTH, one bit wider than the address.
  function automatic int lvl_width(input int addr_size);
    return addr_size + 1;
  endfunction

  // Binary to reflected gray code; callers narrow the result to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrapping binary FIFO pointer with increment enable and synchronous reset.
// PTR_W is ADDR_SIZE+1 so the pointer wraps modulo 2*DEPTH.
// Optional gray output when SYNC_FIFO_GRAY_PTR_EN is defined.
module fifo_ptr_cnt
  import axi_xbar_fifo_pkg::*;
#(
  parameter int PTR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o,
  output logic [PTR_W-1:0] ptr_next_o
`ifdef SYNC_FIFO_GRAY_PTR_EN
  ,
  output logic [PTR_W-1:0] ptr_gray_o
`endif
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Natural binary wrap at 2**PTR_W gives the modulo-2*DEPTH behaviour for free.
  assign ptr_d = ptr_q + PTR_W'(inc_i);

  // Pointer register; reset returns it to entry 0.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`ifdef SYNC_FIFO_GRAY_PTR_EN
  logic [PTR_W-1:0] gray_q;

  // Gray copy registered from the next pointer so it lines up with ptr_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q <= '0;
    end else begin
      gray_q <= PTR_W'(bin2gray(32'(ptr_d)));
    end
  end

  assign ptr_gray_o = gray_q;
`endif

  assign ptr_o      = ptr_q;
  assign ptr_next_o = ptr_d;

endmodule

// File: rtl/sync_fifo_ptr_ctrl.sv
// Single-clock FIFO pointer/flag controller driving an external dual-port RAM.
// Tracks write/read pointers, occupancy, full/empty, programmable almost
// thresholds and sticky overflow/underflow.
// Optional macro SYNC_FIFO_GRAY_PTR_EN adds registered gray pointer outputs.
module sync_fifo_ptr_ctrl
  import axi_xbar_fifo_pkg::*;
#(
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE:0]   afull_thresh,
  input  logic [ADDR_SIZE:0]   aempty_thresh,
  input  logic                 err_clr,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic                 wr_fire,
  output logic                 rd_fire,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   level,
  output logic                 overflow,
  output logic                 underflow
`ifdef SYNC_FIFO_GRAY_PTR_EN
  ,
  output logic [ADDR_SIZE:0]   wr_ptr_gray,
  output logic [ADDR_SIZE:0]   rd_ptr_gray
`endif
);

  localparam int               LVL_W     = lvl_width(ADDR_SIZE);
  localparam int               DEPTH     = 1 << ADDR_SIZE;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

  logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] rd_ptr_q, rd_ptr_d;

  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  // Acceptance from the registered flags; reset blocks any RAM access that cycle.
  assign wr_fire = wr_en & ~full_q & ~rst;
  assign rd_fire = rd_en & ~empty_q & ~rst;

  fifo_ptr_cnt #(
    .PTR_W (LVL_W)
  ) u_wr_ptr (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (wr_fire),
    .ptr_o      (wr_ptr_q),
    .ptr_next_o (wr_ptr_d)
`ifdef SYNC_FIFO_GRAY_PTR_EN
    ,
    .ptr_gray_o (wr_ptr_gray)
`endif
  );

  fifo_ptr_cnt #(
    .PTR_W (LVL_W)
  ) u_rd_ptr (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (rd_fire),
    .ptr_o      (rd_ptr_q),
    .ptr_next_o (rd_ptr_d)
`ifdef SYNC_FIFO_GRAY_PTR_EN
    ,
    .ptr_gray_o (rd_ptr_gray)
`endif
  );

  // Next-state occupancy, flags and sticky errors.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    level_d  = '0;
    full_d   = 1'b0;
    empty_d  = 1'b1;
    afull_d  = 1'b0;
    aempty_d = 1'b1;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;

    // Pointer distance equals level + wr_fire - rd_fire since level never exceeds DEPTH
    // and the pointers wrap at 2*DEPTH.
    level_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (level_d == DEPTH_LVL);
    empty_d  = (level_d == '0);
    afull_d  = (level_d >= afull_thresh);
    aempty_d = (level_d <= aempty_thresh);

    // A new error event wins over a simultaneous clear.
    ovf_d = (wr_en & full_q) | (ovf_q & ~err_clr);
    udf_d = (rd_en & empty_q) | (udf_q & ~err_clr);
  end

  // Status registers, loaded from next-state values so flags track level without lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Wrap bits only matter for the distance computation, not for RAM addressing.
  logic unused_ptr_msbs;
  assign unused_ptr_msbs = wr_ptr_q[ADDR_SIZE] ^ rd_ptr_q[ADDR_SIZE];

  assign wr_addr      = wr_ptr_q[ADDR_SIZE-1:0];
  assign rd_addr      = rd_ptr_q[ADDR_SIZE-1:0];
  assign level        = level_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ptr_ctrl.sv
// Self-checking bench for sync_fifo_ptr_ctrl (ADDR_SIZE=4, DEPTH=16).
// Reference model: a queue holding the RAM address of every stored entry.
module tb_sync_fifo_ptr_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, err_clr;
  logic [AW:0]   afull_thresh, aempty_thresh;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          wr_fire, rd_fire, full, empty, almost_full, almost_empty;
  logic [AW:0]   level;
  logic          overflow, underflow;
`ifdef SYNC_FIFO_GRAY_PTR_EN
  logic [AW:0]   wr_ptr_gray, rd_ptr_gray;
`endif

  sync_fifo_ptr_ctrl #(.ADDR_SIZE(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .afull_thresh  (afull_thresh),
    .aempty_thresh (aempty_thresh),
    .err_clr       (err_clr),
    .wr_addr       (wr_addr),
    .rd_addr       (rd_addr),
    .wr_fire       (wr_fire),
    .rd_fire       (rd_fire),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .level         (level),
    .overflow      (overflow),
    .underflow     (underflow)
`ifdef SYNC_FIFO_GRAY_PTR_EN
    ,
    .wr_ptr_gray   (wr_ptr_gray),
    .rd_ptr_gray   (rd_ptr_gray)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: stored entries are the RAM slots they were written to.
  int q[$];
  int m_wp = 0;   // total writes modulo 2*DEPTH
  int m_rp = 0;   // total reads modulo 2*DEPTH
  bit m_af = 1'b0;
  bit m_ae = 1'b1;
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: inputs driven mid-cycle, combinational outputs
  // checked before the edge, registered outputs checked just after it.
  task automatic step(input bit w, input bit r, input bit c, input bit rs);
    bit was_full, was_empty, exp_wf, exp_rf;
    wr_en   = w;
    rd_en   = r;
    err_clr = c;
    rst     = rs;
    #1;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    exp_wf = w && !was_full && !rs;
    exp_rf = r && !was_empty && !rs;
    check("wr_fire", 32'(wr_fire), 32'(exp_wf));
    check("rd_fire", 32'(rd_fire), 32'(exp_rf));
    if (!rs) begin
      check("wr_addr", 32'(wr_addr), 32'(m_wp % DEPTH));
      check("rd_addr", 32'(rd_addr), 32'(m_rp % DEPTH));
      if (q.size() > 0) check("rd_addr_entry", 32'(rd_addr), 32'(q[0]));
    end

    if (rs) begin
      q.delete();
      m_wp = 0;  m_rp = 0;
      m_af = 1'b0; m_ae = 1'b1;
      m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      m_ovf = (w && was_full) || (m_ovf && !c);
      m_udf = (r && was_empty) || (m_udf && !c);
      if (exp_rf) begin
        void'(q.pop_front());
        m_rp = (m_rp + 1) % (2 * DEPTH);
      end
      if (exp_wf) begin
        q.push_back(m_wp % DEPTH);
        m_wp = (m_wp + 1) % (2 * DEPTH);
      end
      m_af = (q.size() >= int'(afull_thresh));
      m_ae = (q.size() <= int'(aempty_thresh));
    end

    @(posedge clk);
    #1;
    check("level",        32'(level),        32'(q.size()));
    check("full",         32'(full),         32'(q.size() == DEPTH));
    check("empty",        32'(empty),        32'(q.size() == 0));
    check("almost_full",  32'(almost_full),  32'(m_af));
    check("almost_empty", 32'(almost_empty), 32'(m_ae));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_udf));
`ifdef SYNC_FIFO_GRAY_PTR_EN
    check("wr_ptr_gray",  32'(wr_ptr_gray),  32'(m_wp ^ (m_wp >> 1)));
    check("rd_ptr_gray",  32'(rd_ptr_gray),  32'(m_rp ^ (m_rp >> 1)));
`endif
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    afull_thresh  = 5'd12;
    aempty_thresh = 5'd2;
    @(posedge clk);
    #1;

    // Reset state.
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Fill from empty, then one write too many.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Drain from full, then one read too many, then clear the sticky flags.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);

    // Simultaneous request while empty: write only.
    step(1, 1, 0, 0);
    step(0, 0, 1, 0);

    // Simultaneous request while full: read only.
    for (int i = 0; i < DEPTH - 1; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 1, 0);

    // Simultaneous request at level 8: level holds, pointers advance.
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);

    // Wrap: 40 write/read pairs at level 3.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0);

    // Threshold change at level 10: almost_full follows on the next edge.
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
    afull_thresh = 5'd8;
    step(0, 0, 0, 0);
    afull_thresh = 5'd0;
    step(0, 1, 0, 0);
    afull_thresh = 5'd20;
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    afull_thresh = 5'd12;
    step(0, 0, 0, 0);

    // Reset mid-stream at level 9 with a pending write.
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);

    // Randomized traffic with occasional clears, resets and threshold changes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        afull_thresh  = 5'($urandom_range(0, 20));
        aempty_thresh = 5'($urandom_range(0, 20));
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
